// File: rtl/gb_video_pkg.sv
// +----------------------------------------------------------------------+
// | gb_video_pkg                                                         |
// | Geometry and capture-state definitions shared by the video path.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package gb_video_pkg;

  localparam int GB_WIDTH  = 160;
  localparam int GB_HEIGHT = 144;
  localparam int GB_PIXELS = GB_WIDTH * GB_HEIGHT;
  localparam int GB_ADDR_W = 15;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/gb_sync_edge.sv
// +----------------------------------------------------------------------+
// | gb_sync_edge                                                         |
// | Multi-flop synchronizer for one asynchronous bit with rise detect.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module gb_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic sync,
  output logic rise
);

  logic [STAGES-1:0] r_chain;
  logic              r_hist;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
      r_hist  <= 1'b0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], async_in};
      r_hist  <= r_chain[STAGES-1];
    end
  end

  assign sync = r_chain[STAGES-1];
  assign rise = r_chain[STAGES-1] & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/gb_lcd_capture.sv
// +----------------------------------------------------------------------+
// | gb_lcd_capture                                                       |
// | Oversampled Game Boy LCD bus capture into a frame-RAM write stream.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module gb_lcd_capture
  import gb_video_pkg::*;
#(
  parameter int WIDTH       = GB_WIDTH,
  parameter int HEIGHT      = GB_HEIGHT,
  parameter int ADDR_W      = GB_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              lcd_cp,
  input  logic              lcd_hsync,
  input  logic              lcd_vsync,
  input  logic [1:0]        lcd_d,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              locked,
  output logic              err_short,
  output logic              err_long
);

  localparam int                c_x_w       = $clog2(WIDTH + 1);
  localparam int                c_y_w       = $clog2(HEIGHT + 1);
  localparam logic [c_x_w-1:0]  c_x_max     = c_x_w'(WIDTH);
  localparam logic [c_y_w-1:0]  c_y_last    = c_y_w'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] c_line_step = ADDR_W'(WIDTH);

  logic w_cp_sync, w_cp_rise;
  logic w_hs_sync, w_hs_rise;
  logic w_vs_sync, w_vs_rise;
  logic w_unused_sync;

  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cp (
    .clk_in(clk_in), .rst(rst), .async_in(lcd_cp),    .sync(w_cp_sync), .rise(w_cp_rise)
  );
  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_hs (
    .clk_in(clk_in), .rst(rst), .async_in(lcd_hsync), .sync(w_hs_sync), .rise(w_hs_rise)
  );
  gb_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vs (
    .clk_in(clk_in), .rst(rst), .async_in(lcd_vsync), .sync(w_vs_sync), .rise(w_vs_rise)
  );

  assign w_unused_sync = w_cp_sync & w_hs_sync & w_vs_sync;

  // Same depth as the cp chain so the data word lines up with cp_rise.
  logic [SYNC_STAGES-1:0][1:0] r_d_sync;
  logic [1:0]                  w_d;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_d_sync <= '0;
    else     r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], lcd_d};
  end

  assign w_d = r_d_sync[SYNC_STAGES-1];

  cap_state_e        r_state, w_state_nxt;
  logic [c_x_w-1:0]  r_x, w_x_nxt;
  logic [c_y_w-1:0]  r_y, w_y_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_line_base, w_line_base_nxt;
  logic              r_frame_bad, w_frame_bad_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_err_short, w_err_short_nxt;
  logic              r_err_long, w_err_long_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [1:0]        r_wr_data, w_wr_data_nxt;
  logic              r_frame_start, w_frame_start_nxt;
  logic              r_frame_done, w_frame_done_nxt;
  logic              w_take_cp;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state       <= SEEK;
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
      r_line_base   <= '0;
      r_frame_bad   <= 1'b0;
      r_locked      <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_addr        <= w_addr_nxt;
      r_line_base   <= w_line_base_nxt;
      r_frame_bad   <= w_frame_bad_nxt;
      r_locked      <= w_locked_nxt;
      r_err_short   <= w_err_short_nxt;
      r_err_long    <= w_err_long_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_wr_data     <= w_wr_data_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_done  <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_addr_nxt        = r_addr;
    w_line_base_nxt   = r_line_base;
    w_frame_bad_nxt   = r_frame_bad;
    w_locked_nxt      = r_locked;
    w_err_short_nxt   = r_err_short;
    w_err_long_nxt    = r_err_long;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_frame_start_nxt = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_take_cp         = 1'b0;

    // vsync outranks everything; a coincident cp becomes pixel (0,0).
    if (w_vs_rise) begin
      if (r_state == ACTIVE) w_locked_nxt = 1'b0;
      w_state_nxt       = ACTIVE;
      w_x_nxt           = '0;
      w_y_nxt           = '0;
      w_addr_nxt        = '0;
      w_line_base_nxt   = '0;
      w_frame_bad_nxt   = 1'b0;
      w_frame_start_nxt = 1'b1;
      w_take_cp         = w_cp_rise;
    end else begin
      case (r_state)
        ACTIVE: begin
          w_take_cp = w_cp_rise;
          if (w_hs_rise && (r_x != '0)) begin
            if (r_x < c_x_max) begin
              w_err_short_nxt = 1'b1;
              w_frame_bad_nxt = 1'b1;
            end
            w_x_nxt         = '0;
            w_y_nxt         = r_y + c_y_w'(1);
            w_line_base_nxt = r_line_base + c_line_step;
            w_addr_nxt      = r_line_base + c_line_step;
            if (r_y == c_y_last) begin
              w_frame_done_nxt = 1'b1;
              w_locked_nxt     = ~w_frame_bad_nxt;
              w_state_nxt      = DONE;
              w_take_cp        = 1'b0;
            end
          end
        end
        SEEK, DONE: begin
        end
        default: w_state_nxt = SEEK;
      endcase
    end

    if (w_take_cp) begin
      if (w_x_nxt < c_x_max) begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = w_addr_nxt;
        w_wr_data_nxt = w_d;
        w_x_nxt       = w_x_nxt + c_x_w'(1);
        w_addr_nxt    = w_addr_nxt + ADDR_W'(1);
      end else begin
        // An overlong line also spoils the frame, so locked stays low at its end.
        w_err_long_nxt  = 1'b1;
        w_locked_nxt    = 1'b0;
        w_frame_bad_nxt = 1'b1;
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign locked      = r_locked;
  assign err_short   = r_err_short;
  assign err_long    = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_gb_lcd_capture.sv
// +----------------------------------------------------------------------+
// | tb_gb_lcd_capture                                                    |
// | Table-driven frame vectors plus directed corner-case sequences.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gb_lcd_capture;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int AW = 8;
  localparam int NS = 2;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          lcd_cp = 1'b0;
  logic          lcd_hsync = 1'b0;
  logic          lcd_vsync = 1'b0;
  logic [1:0]    lcd_d = 2'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic          frame_start, frame_done, locked, err_short, err_long;

  gb_lcd_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .SYNC_STAGES(NS)) dut (
    .clk_in(clk_in), .rst(rst), .lcd_cp(lcd_cp), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_d(lcd_d), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_start(frame_start), .frame_done(frame_done),
    .locked(locked), .err_short(err_short), .err_long(err_long)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  bit [AW+1:0] act_q[$];
  bit [AW+1:0] exp_q[$];
  int act_rd = 0;
  int n_start = 0, n_done = 0, n_consec = 0;
  int st0, dn0, consec0 = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk_in) begin
    if (wr_en) act_q.push_back({wr_addr, wr_data});
    if (wr_en && prev_wr) n_consec++;
    if (frame_start) n_start++;
    if (frame_done) n_done++;
    prev_wr = wr_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic check_writes(input string name);
    int na;
    na = act_q.size() - act_rd;
    chk({name, " write count"}, na, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < na; i++)
      chk($sformatf("%s write %0d {addr,data}", name, i), act_q[act_rd + i], exp_q[i]);
    act_rd = act_q.size();
    exp_q.delete();
    chk({name, " wr_en spacing"}, n_consec - consec0, 0);
    consec0 = n_consec;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pix(input logic [1:0] d);
    lcd_d = d; lcd_cp = 1'b1; cyc(3);
    lcd_cp = 1'b0; cyc(3);
  endtask

  task automatic hs();
    lcd_hsync = 1'b1; cyc(3);
    lcd_hsync = 1'b0; cyc(3);
  endtask

  task automatic vs();
    lcd_vsync = 1'b1; cyc(3);
    lcd_vsync = 1'b0; cyc(3);
  endtask

  task automatic hs_pix(input logic [1:0] d);
    lcd_d = d; lcd_hsync = 1'b1; lcd_cp = 1'b1; cyc(3);
    lcd_hsync = 1'b0; lcd_cp = 1'b0; cyc(3);
  endtask

  task automatic vs_pix(input logic [1:0] d);
    lcd_d = d; lcd_vsync = 1'b1; lcd_cp = 1'b1; cyc(3);
    lcd_vsync = 1'b0; lcd_cp = 1'b0; cyc(3);
  endtask

  task automatic line_px(input int y, input int from, input int n);
    for (int i = from; i < n; i++) begin
      pix(2'(i));
      if (i < W) exp_q.push_back({AW'(y * W + i), 2'(i)});
    end
  endtask

  task automatic line(input int y, input int n);
    line_px(y, 0, n);
    hs();
  endtask

  task automatic snap();
    st0 = n_start;
    dn0 = n_done;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(3);
    chk("reset outputs", {wr_en, wr_addr, wr_data, frame_start, frame_done,
                          locked, err_short, err_long}, 0);
    rst = 1'b0; cyc(3);
  endtask

  typedef struct {
    int short_line;
    int short_len;
    int long_line;
    int long_len;
    bit exp_locked;
    bit exp_err_short;
    bit exp_err_long;
  } row_t;

  row_t rows[5];

  initial begin
    int lat;
    rows[0] = '{-1, 0,  -1, 0,     1'b1, 1'b0, 1'b0};
    rows[1] = '{5,  10, -1, 0,     1'b0, 1'b1, 1'b0};
    rows[2] = '{-1, 0,  0,  W + 5, 1'b0, 1'b0, 1'b1};
    rows[3] = '{2,  12, 7,  W + 2, 1'b0, 1'b1, 1'b1};
    rows[4] = '{H - 1, 1, -1, 0,   1'b0, 1'b1, 1'b0};

    @(negedge clk_in);

    for (int r = 0; r < 5; r++) begin
      do_reset();
      snap();
      vs();
      for (int y = 0; y < H; y++) begin
        int n;
        n = W;
        if (y == rows[r].short_line) n = rows[r].short_len;
        if (y == rows[r].long_line) n = rows[r].long_len;
        line(y, n);
      end
      cyc(2);
      chk($sformatf("row%0d frame_start pulses", r), n_start - st0, 1);
      chk($sformatf("row%0d frame_done pulses", r), n_done - dn0, 1);
      chk($sformatf("row%0d locked", r), locked, rows[r].exp_locked);
      chk($sformatf("row%0d err_short", r), err_short, rows[r].exp_err_short);
      chk($sformatf("row%0d err_long", r), err_long, rows[r].exp_err_long);
      pix(2'd1); pix(2'd2); hs();
      chk($sformatf("row%0d frame_done after DONE traffic", r), n_done - dn0, 1);
      check_writes($sformatf("row%0d", r));
    end

    // vs+cp together, hs+cp together entering line 3, and a dropped pixel at frame end
    do_reset();
    snap();
    vs_pix(2'd3);
    exp_q.push_back({AW'(0), 2'd3});
    line_px(0, 1, W); hs();
    line(1, W);
    line_px(2, 0, W);
    hs_pix(2'd2);
    exp_q.push_back({AW'(3 * W), 2'd2});
    line_px(3, 1, W); hs();
    for (int y = 4; y < H - 1; y++) line(y, W);
    line_px(H - 1, 0, W);
    hs_pix(2'd1);
    cyc(2);
    chk("coincident frame_done pulses", n_done - dn0, 1);
    chk("coincident locked", locked, 1);
    check_writes("coincident");

    // Early vsync during line 7 after a locked frame
    snap();
    vs();
    for (int y = 0; y < 7; y++) line(y, W);
    line_px(7, 0, 3);
    vs();
    chk("early vsync frame_start pulses", n_start - st0, 2);
    chk("early vsync frame_done pulses", n_done - dn0, 0);
    chk("early vsync locked", locked, 0);
    chk("early vsync err_short", err_short, 0);
    pix(2'd1); pix(2'd2);
    exp_q.push_back({AW'(0), 2'd1});
    exp_q.push_back({AW'(1), 2'd2});
    check_writes("early vsync");

    // Asynchronous reset in the middle of line 4
    vs();
    line(0, W); line(1, W); line(2, 10); line(3, W);
    line_px(4, 0, 5);
    chk("pre-reset err_short", err_short, 1);
    check_writes("pre-reset");
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", {wr_en, wr_addr, wr_data, frame_start, frame_done,
                                locked, err_short, err_long}, 0);
    cyc(3);
    rst = 1'b0;
    cyc(2);
    for (int i = 5; i < W; i++) pix(2'(i));
    hs(); pix(2'd3); hs();
    check_writes("post-reset idle");

    snap();
    vs();
    lat = 0;
    lcd_d = 2'd2; lcd_cp = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (lat == 0 && wr_en) lat = k;
    end
    lcd_cp = 1'b0; cyc(3);
    chk("cp to wr_en latency in range", (lat >= NS + 1 && lat <= NS + 3) ? 1 : 0, 1);
    exp_q.push_back({AW'(0), 2'd2});
    line_px(0, 1, W); hs();
    for (int y = 1; y < H; y++) line(y, W);
    cyc(2);
    chk("post-reset frame_done pulses", n_done - dn0, 1);
    chk("post-reset locked", locked, 1);
    chk("post-reset err_short", err_short, 0);
    check_writes("post-reset frame");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/gb_lcd_capture.md
# gb_lcd_capture

Front end of the video path: oversamples the raw, asynchronous Game Boy LCD bus (pixel clock, hsync, vsync, 2-bit data) with the fast system clock. It produces a clean, single-clock write stream of pixel, address and enable into the dual-port frame RAM, and the video buffer reads that RAM out. It replaces gated-clock capture with edge detection, frame/line tracking and geometry-error reporting.

## Interface
- WIDTH, 160, active pixels per line
- HEIGHT, 144, active lines per frame
- ADDR_W, 15, write-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- SYNC_STAGES, 2, synchronizer flops per input, ≥2
- clk_in  in  1  sampling/system clock; must run ≥4× lcd_cp frequency
- rst  in  1  reset, asynchronous, active-high
- lcd_cp  in  1  raw LCD pixel clock, asynchronous
- lcd_hsync  in  1  raw line sync, active-high, asynchronous
- lcd_vsync  in  1  raw frame sync, active-high, asynchronous
- lcd_d  in  2  raw pixel data, asynchronous, valid at lcd_cp rising edge
- wr_en  out  1  one-cycle write strobe to frame RAM
- wr_addr  out  ADDR_W  y*WIDTH + x of the written pixel
- wr_data  out  2  captured pixel
- frame_start  out  1  one-cycle pulse on accepted vsync
- frame_done  out  1  one-cycle pulse after line HEIGHT-1 completes
- locked  out  1  last frame completed with exact geometry
- err_short  out  1  sticky: a line ended with x < WIDTH
- err_long  out  1  sticky: a pixel arrived with x == WIDTH

## Operation
- All four control/data inputs pass through SYNC_STAGES flops. lcd_d uses the same depth as lcd_cp so data and edge stay aligned. One extra history flop per control signal supports edge detection.
- Events are derived from synchronized signals: cp_rise, hs_rise, vs_rise.
- FSM states:
  - SEEK (reset state): ignore cp/hs. On vs_rise: x=0, y=0, addr=0, line_base=0, pulse frame_start, go to ACTIVE.
  - ACTIVE:
    - cp_rise with x<WIDTH: write pixel, x++, addr++.
    - cp_rise with x==WIDTH: no write, set err_long, clear locked.
    - hs_rise with x==0: ignored (leading hsync).
    - hs_rise with x>0: if x<WIDTH, set err_short and flag the frame bad. Then y++, x=0, line_base+=WIDTH, addr=line_base+WIDTH.
    - When y becomes HEIGHT: pulse frame_done, set locked = !frame_bad, go to DONE.
    - vs_rise in ACTIVE (early frame): flag bad, clear locked, restart exactly as from SEEK (frame_start pulses, no frame_done).
  - DONE: ignore cp/hs. On vs_rise, act as SEEK.
- Simultaneous events in one clk_in cycle, in priority order:
  - vs_rise is processed first; a coincident cp_rise is written as pixel (0,0), addr 0.
  - hs_rise is processed before a coincident cp_rise; that pixel lands at x=0 of the new line.
  - hs_rise that completes line HEIGHT-1 with a coincident cp_rise: the pixel is dropped.
- Addresses never exceed WIDTH*HEIGHT-1 (23039 with defaults); no wrap-around inside a frame.
- err_short and err_long are cleared only by rst. frame_bad is cleared at each accepted vsync.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_start=0, frame_done=0, locked=0, err_short=0, err_long=0, state=SEEK, all sync flops 0.
- Reset mid-frame aborts immediately. After release, the block waits in SEEK for the next vs_rise; no partial-frame writes.
- Latency: raw lcd_cp rising edge to wr_en high is SYNC_STAGES+2 clk_in cycles (± 1 cycle sampling uncertainty).
- wr_addr and wr_data are registered together with wr_en and valid only while wr_en=1.
- wr_en is never high on two consecutive cycles. The minimum spacing equals the lcd_cp period in clk_in cycles.
- frame_done asserts the cycle after the hs_rise that ends line HEIGHT-1. locked updates in the same cycle.
- Pulses on lcd_cp, lcd_hsync or lcd_vsync shorter than 2 clk_in periods are not guaranteed to be detected.

## Structure
- Package gb_video_pkg holds:
  - GB_WIDTH=160, GB_HEIGHT=144, GB_PIXELS=23040, GB_ADDR_W=15.
  - The capture state enum (SEEK, ACTIVE, DONE).
  - Shared by this block and the video buffer.
- Sub-module gb_sync_edge: an N-stage synchronizer plus rise detector, with outputs sync and rise. It is instantiated for lcd_cp, lcd_hsync and lcd_vsync. lcd_d uses a plain 2-bit synchronizer of equal depth.

## Test plan
- Nominal frame: vsync, then 144 lines of 160 pixels with data = x[1:0]. Required: 23040 writes; addr 0..23039 in order; wr_data matches; one frame_done; locked=1; no errors.
- Short line: line 5 carries 150 pixels. Required: err_short=1; first pixel of line 6 written at addr 960; frame_done still pulses; locked=0.
- Long line: line 0 carries 165 pixels. Required: 160 writes on that line; err_long=1; line 1 starts at addr 160.
- Early vsync after 70 lines. Required: frame_start pulses; next pixel written at addr 0; no frame_done for the aborted frame.
- Coincident events: vs_rise and cp_rise in the same synchronized cycle → write at addr 0. hs_rise and cp_rise together on line 3 → write at addr 480.
- rst asserted mid-line 40, then released. Required: all outputs 0 immediately; no writes until the next vsync; the following full frame gives locked=1.
